ss_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit common-anode seven-segment display. It shares one BCD segment decoder between four digit positions and sequences the active-low anodes at a fixed dwell rate. A load/ack handshake lets upstream counters push new values. Updates are applied only at frame boundaries, so a displayed number never tears mid-scan.

---
 rtl/ss_pkg.sv | 27 ++
 rtl/ss_bcd_dec.sv | 28 ++
 rtl/ss_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_ss_scan_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// ss_pkg: shared constants and types for the seven-segment scan controller.
//   NUM_DIGITS  - digit positions on the display
//   SEG_BLANK   - all segments off (active-low)
//   AN_OFF      - all anodes off (active-low)
//   SEG_0..9    - active-low segment codes, bit 0 = a ... bit 6 = g
//   phase_e     - dwell phase: BLANK (ghosting guard) or SHOW
package ss_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    typedef enum logic {BLANK, SHOW} phase_e;

endpackage

// File: rtl/ss_bcd_dec.sv
// ss_bcd_dec: combinational BCD nibble to active-low seven-segment decoder.
//   bcd  in  4  BCD digit; codes 10-15 decode to blank
//   seg  out 7  active-low segments, seg[0]=a ... seg[6]=g
module ss_bcd_dec
    import ss_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ss_scan_ctrl.sv
// ss_scan_ctrl: time-multiplexed scan controller for a 4-digit common-anode
// seven-segment display. One shared BCD decoder; new values are accepted via a
// load strobe and only take effect at a frame boundary so digits never tear.
//   clk    in  1   system clock
//   rst    in  1   asynchronous active-high reset
//   load   in  1   single-cycle strobe, capture din
//   din    in  16  four BCD nibbles, din[3:0] = digit 0 (rightmost)
//   ack    out 1   pulse: a captured value became the displayed value
//   frame  out 1   pulse in the first cycle of each frame (not after reset)
//   seg    out 7   active-low segments
//   an     out 4   active-low anodes
// Build option: define SS_LZB_EN for leading-zero blanking (digits 3..1 dark
// when they and every higher nibble are zero; anode timing unchanged).
module ss_scan_ctrl
    import ss_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned DIGIT_HZ = 1000,
    parameter int unsigned GUARD    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] din,
    output logic        ack,
    output logic        frame,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int unsigned DWELL = CLK_HZ / DIGIT_HZ;
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    if (DWELL <= GUARD + 1) begin : g_cfg_err
        $error("ss_scan_ctrl: DWELL (CLK_HZ/DIGIT_HZ) must exceed GUARD+1");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      active_q, active_d;
    logic [15:0]      pending_q, pending_d;
    logic             pend_v_q, pend_v_d;
    logic             ack_d, frame_d;
    logic [6:0]       seg_d;
    logic [3:0]       an_d;
    logic             boundary;
    phase_e           phase_d;
    logic [3:0]       nib_d;
    logic [6:0]       dec_seg;
    logic             lzb_blank;

    // Scan sequencing and value hand-off.
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        boundary  = 1'b0;
        active_d  = active_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;
        ack_d     = 1'b0;

        if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            idx_d    = idx_q + 1'b1;
            boundary = (idx_q == IDX_LAST);
        end

        if (boundary) begin
            // A load on the boundary edge wins over any older pending value.
            if (load) begin
                active_d = din;
            end else if (pend_v_q) begin
                active_d = pending_q;
            end
            ack_d    = load | pend_v_q;
            pend_v_d = 1'b0;
        end else if (load) begin
            pending_d = din;
            pend_v_d  = 1'b1;
        end

        frame_d = boundary;
        phase_d = (cnt_d < CNT_GUARD) ? BLANK : SHOW;
        nib_d   = active_d[{idx_d, 2'b00} +: 4];
    end

    ss_bcd_dec u_dec (
        .bcd (nib_d),
        .seg (dec_seg)
    );

`ifdef SS_LZB_EN
    always_comb begin
        lzb_blank = (idx_d != '0);
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if ((IDX_W'(i) >= idx_d) && (active_d[4*i +: 4] != 4'h0)) begin
                lzb_blank = 1'b0;
            end
        end
    end
`else
    assign lzb_blank = 1'b0;
`endif

    // Outputs are registered from the next scan position so an/seg move on
    // the same edge as cnt/idx and never glitch.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (phase_d == SHOW) begin
            an_d[idx_d] = 1'b0;
            seg_d       = lzb_blank ? SEG_BLANK : dec_seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            active_q  <= '0;
            pending_q <= '0;
            pend_v_q  <= 1'b0;
            ack       <= 1'b0;
            frame     <= 1'b0;
            seg       <= SEG_BLANK;
            an        <= AN_OFF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pend_v_q  <= pend_v_d;
            ack       <= ack_d;
            frame     <= frame_d;
            seg       <= seg_d;
            an        <= an_d;
        end
    end

endmodule

// File: tb/tb_ss_scan_ctrl.sv
// tb_ss_scan_ctrl: self-checking bench for ss_scan_ctrl with DWELL=10, GUARD=2.
// The reference model tracks time since reset as a plain cycle count and
// derives the expected display from frame position arithmetic and a code table.
module tb_ss_scan_ctrl;

    localparam int DW    = 10;
    localparam int GD    = 2;
    localparam int FRAME = 4 * DW;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] din;
    logic        ack;
    logic        frame;
    logic [6:0]  seg;
    logic [3:0]  an;

    int asserts = 0;
    int fails   = 0;

    // Reference model state.
    int          t;
    logic [15:0] m_active;
    logic [15:0] m_pend_val;
    bit          m_pend;
    bit          m_ack;
    bit          m_frame;

    logic [6:0] seg_tab [16];

    ss_scan_ctrl #(
        .CLK_HZ   (1000),
        .DIGIT_HZ (100),
        .GUARD    (GD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .din   (din),
        .ack   (ack),
        .frame (frame),
        .seg   (seg),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_an();
        int p = t % FRAME;
        if (p % DW < GD) return 4'b1111;
        return ~(4'b0001 << (p / DW));
    endfunction

    function automatic logic [6:0] exp_seg();
        int p = t % FRAME;
        int d = p / DW;
        logic [15:0] upper;
        if (p % DW < GD) return 7'b1111111;
        upper = m_active >> (4 * d);
`ifdef SS_LZB_EN
        if (d > 0 && upper == 16'h0) return 7'b1111111;
`endif
        return seg_tab[upper[3:0]];
    endfunction

    function automatic logic [12:0] exp_vec();
        return {exp_an(), exp_seg(), m_ack, m_frame};
    endfunction

    task automatic model_reset();
        t          = 0;
        m_active   = 16'h0;
        m_pend_val = 16'h0;
        m_pend     = 0;
        m_ack      = 0;
        m_frame    = 0;
    endtask

    // Drive one cycle, advance the model across the edge, return at edge+1.
    task automatic step(input logic ld, input logic [15:0] d);
        bit bnd;
        load = ld;
        din  = d;
        @(posedge clk);
        bnd     = (t % FRAME == FRAME - 1);
        m_ack   = 0;
        m_frame = bnd;
        if (bnd) begin
            if (ld) begin
                m_active = d;
                m_ack    = 1;
            end else if (m_pend) begin
                m_active = m_pend_val;
                m_ack    = 1;
            end
            m_pend = 0;
        end else if (ld) begin
            m_pend_val = d;
            m_pend     = 1;
        end
        t++;
        #1;
        load = 1'b0;
    endtask

    task automatic advance_to(input int pos);
        while (t % FRAME != pos) step(1'b0, 16'h0);
    endtask

    task automatic test_reset();
        #2;
        asserts++;
        if ({an, seg, ack, frame} !== {4'b1111, 7'b1111111, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_hold got=%b required=%b", {an, seg, ack, frame},
                     {4'b1111, 7'b1111111, 2'b00});
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        asserts++;
        if ({an, seg, ack, frame} !== exp_vec()) begin
            fails++;
            $display("FAIL reset_release got=%b required=%b", {an, seg, ack, frame}, exp_vec());
        end
    endtask

    task automatic test_scan_no_load();
        int first_frame = -1;
        for (int k = 0; k < 45; k++) begin
            step(1'b0, 16'h0);
            if (frame === 1'b1 && first_frame < 0) first_frame = t;
            asserts++;
            if ({an, seg, ack, frame} !== exp_vec()) begin
                fails++;
                $display("FAIL scan_idle t=%0d got=%b required=%b", t, {an, seg, ack, frame},
                         exp_vec());
            end
        end
        asserts++;
        if (first_frame != 40) begin
            fails++;
            $display("FAIL first_frame cycle got=%0d required=40", first_frame);
        end
    endtask

    task automatic test_load_mid_frame();
        int acks = 0;
        advance_to(15);
        step(1'b1, 16'h1234);
        for (int k = 0; k < 70; k++) begin
            step(1'b0, 16'h0);
            acks += int'(ack);
            asserts++;
            if ({an, seg, ack, frame} !== exp_vec()) begin
                fails++;
                $display("FAIL load_mid t=%0d got=%b required=%b", t, {an, seg, ack, frame},
                         exp_vec());
            end
            if (t % FRAME == 5 && m_active == 16'h1234) begin
                asserts++;
                if (seg !== 7'b0011001) begin
                    fails++;
                    $display("FAIL load_mid_digit0 got=%b required=0011001", seg);
                end
            end
        end
        asserts++;
        if (acks != 1) begin
            fails++;
            $display("FAIL load_mid_ack_count got=%0d required=1", acks);
        end
    endtask

    task automatic test_double_load();
        int acks = 0;
        advance_to(5);
        step(1'b1, 16'h0005);
        step(1'b1, 16'h0009);
        for (int k = 0; k < 50; k++) begin
            step(1'b0, 16'h0);
            acks += int'(ack);
            asserts++;
            if ({an, seg, ack, frame} !== exp_vec()) begin
                fails++;
                $display("FAIL double_load t=%0d got=%b required=%b", t, {an, seg, ack, frame},
                         exp_vec());
            end
        end
        asserts++;
        if (acks != 1) begin
            fails++;
            $display("FAIL double_load_ack_count got=%0d required=1", acks);
        end
    endtask

    task automatic test_boundary_load();
        advance_to(20);
        step(1'b1, 16'h0777);
        advance_to(FRAME - 1);
        step(1'b1, 16'h0042);
        asserts++;
        if (ack !== 1'b1 || frame !== 1'b1) begin
            fails++;
            $display("FAIL bypass_ack got ack=%b frame=%b required 1 1", ack, frame);
        end
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 16'h0);
            asserts++;
            if ({an, seg, ack, frame} !== exp_vec()) begin
                fails++;
                $display("FAIL bypass t=%0d got=%b required=%b", t, {an, seg, ack, frame},
                         exp_vec());
            end
            if (t % FRAME == 32) begin
                asserts++;
`ifdef SS_LZB_EN
                if ({an, seg} !== {4'b0111, 7'b1111111}) begin
`else
                if ({an, seg} !== {4'b0111, 7'b1000000}) begin
`endif
                    fails++;
                    $display("FAIL bypass_digit3 got an=%b seg=%b", an, seg);
                end
            end
        end
    endtask

    task automatic test_invalid_nibble();
        advance_to(3);
        step(1'b1, 16'h00B7);
        for (int k = 0; k < 60; k++) begin
            step(1'b0, 16'h0);
            asserts++;
            if ({an, seg, ack, frame} !== exp_vec()) begin
                fails++;
                $display("FAIL bad_nibble t=%0d got=%b required=%b", t, {an, seg, ack, frame},
                         exp_vec());
            end
            if (t % FRAME == 15 && m_active == 16'h00B7) begin
                asserts++;
                if ({an, seg} !== {4'b1101, 7'b1111111}) begin
                    fails++;
                    $display("FAIL bad_nibble_digit1 got an=%b seg=%b", an, seg);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(7) == 0), 16'($urandom));
            asserts++;
            if ({an, seg, ack, frame} !== exp_vec()) begin
                fails++;
                $display("FAIL random t=%0d got=%b required=%b", t, {an, seg, ack, frame},
                         exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        advance_to(13);
        step(1'b1, 16'h7777);
        #2;
        rst = 1'b1;
        #1;
        asserts++;
        if ({an, seg, ack, frame} !== {4'b1111, 7'b1111111, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL async_reset got=%b required=%b", {an, seg, ack, frame},
                     {4'b1111, 7'b1111111, 2'b00});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 45; k++) begin
            step(1'b0, 16'h0);
            acks += int'(ack);
            asserts++;
            if ({an, seg, ack, frame} !== exp_vec()) begin
                fails++;
                $display("FAIL after_reset t=%0d got=%b required=%b", t, {an, seg, ack, frame},
                         exp_vec());
            end
        end
        asserts++;
        if (acks != 0) begin
            fails++;
            $display("FAIL after_reset_ack_count got=%0d required=0", acks);
        end
    endtask

    initial begin
        seg_tab[0] = 7'b1000000;
        seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001;
        seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010;
        seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111111;

        rst  = 1'b1;
        load = 1'b0;
        din  = 16'h0;
        model_reset();

        test_reset();
        test_scan_no_load();
        test_load_mid_frame();
        test_double_load();
        test_boundary_load();
        test_invalid_nibble();
        test_random();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
